// File: rtl/mux_stream_rr_if.sv
// rtl/mux_stream_rr_if.sv - stream bundle between N producers, the mux and one consumer
interface mux_stream_rr_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic [SELW-1:0]    out_chan;
    logic               out_ready;

    // Mux side of the bundle
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        output out_chan,
        input  out_ready
    );

    // Producer/consumer side of the bundle
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_chan,
        output out_ready
    );
endinterface

// File: rtl/mux_stream_rr.sv
// rtl/mux_stream_rr.sv - registered N-channel stream mux with manual or round-robin grant
module mux_stream_rr #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    mux_stream_rr_if.slave       bus
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             grant_ok;
    logic             xfer;
    logic [SELW-1:0]  grant;
    logic [SELW:0]    idx_w;
    logic [N-1:0]     in_ready_w;

    assign load_en = !out_valid_q || bus.out_ready;

    // Scan from the highest offset down so the lowest offset from ptr wins
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        idx_w    = '0;
        if (!mode) begin
            grant    = sel;
            grant_ok = ({1'b0, sel} < (SELW+1)'(N));
        end else begin
            grant_ok = |bus.in_valid;
            for (int k = N - 1; k >= 0; k--) begin
                idx_w = {1'b0, ptr_q} + (SELW+1)'(k);
                if (idx_w >= (SELW+1)'(N))
                    idx_w = idx_w - (SELW+1)'(N);
                if (bus.in_valid[idx_w[SELW-1:0]])
                    grant = idx_w[SELW-1:0];
            end
        end
    end

    // rst_n gating keeps every ready low while reset is held
    always_comb begin
        in_ready_w = '0;
        for (int i = 0; i < N; i++)
            in_ready_w[i] = rst_n && load_en && grant_ok && (grant == SELW'(i));
    end

    assign xfer = |(bus.in_valid & in_ready_w);

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = bus.in_data[grant*WIDTH +: WIDTH];
                out_chan_d = grant;
                if (mode)
                    ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_mux_stream_rr.sv
// tb/tb_mux_stream_rr.sv - scoreboard bench for mux_stream_rr
module tb_mux_stream_rr;
    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    int         total;
    int         bad;

    mux_stream_rr_if #(.WIDTH(8), .N(4)) bus ();

    mux_stream_rr #(.WIDTH(8), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: expected {chan, data} words queued at drive time
    logic [9:0] exp_q[$];
    int         m_ptr;
    logic       m_valid;

    task automatic set_data(input logic [7:0] d0, d1, d2, d3);
        bus.in_data = {d3, d2, d1, d0};
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    // One clock: predict grant, check in_ready, clock, pop scoreboard
    task automatic cycle();
        int         g;
        logic       ok;
        logic       load;
        logic       pushed;
        logic [3:0] exp_rdy;
        logic [9:0] e;
        #1;
        g  = 0;
        ok = 1'b0;
        load = !m_valid || bus.out_ready;
        if (!mode) begin
            g  = int'(sel);
            ok = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!ok && bus.in_valid[(m_ptr + k) % 4]) begin
                    g  = (m_ptr + k) % 4;
                    ok = 1'b1;
                end
            end
        end
        exp_rdy = (load && ok) ? (4'b0001 << g) : 4'b0000;
        total++;
        if (bus.in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready: got %b expected %b", bus.in_ready, exp_rdy);
        end
        pushed = 1'b0;
        if (load) begin
            if (ok && bus.in_valid[g]) begin
                exp_q.push_back({2'(g), bus.in_data[g*8 +: 8]});
                pushed  = 1'b1;
                m_valid = 1'b1;
                if (mode) m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== m_valid) begin
            bad++;
            $display("FAIL out_valid: got %b expected %b", bus.out_valid, m_valid);
        end
        if (pushed) begin
            e = exp_q.pop_front();
            total++;
            if ({bus.out_chan, bus.out_data} !== e) begin
                bad++;
                $display("FAIL sb_word: got chan=%0d data=%h expected chan=%0d data=%h",
                         bus.out_chan, bus.out_data, e[9:8], e[7:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            mode          = 1'($urandom);
            sel           = 2'($urandom);
            bus.in_valid  = 4'($urandom);
            bus.in_data   = $urandom;
            bus.out_ready = 1'($urandom);
            #2;
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_chan, bus.in_ready} !== 15'd0) begin
                bad++;
                $display("FAIL reset_state: got v=%b d=%h c=%0d rdy=%b expected all zero",
                         bus.out_valid, bus.out_data, bus.out_chan, bus.in_ready);
            end
        end
        @(posedge clk);
        #1;
        mode          = 1'b0;
        sel           = 2'd2;
        bus.in_valid  = 4'b0100;
        bus.out_ready = 1'b1;
        set_data(8'h00, 8'h00, 8'hA5, 8'h00);
        rst_n         = 1'b1;
        cycle();
        total++;
        if ({bus.out_valid, bus.out_chan, bus.out_data} !== {1'b1, 2'd2, 8'hA5}) begin
            bad++;
            $display("FAIL reset_release: got v=%b c=%0d d=%h expected v=1 c=2 d=a5",
                     bus.out_valid, bus.out_chan, bus.out_data);
        end
    endtask

    task automatic test_manual_sweep();
        logic [7:0] exp_d[4];
        exp_d = '{8'h10, 8'h21, 8'h32, 8'h43};
        set_data(8'h10, 8'h21, 8'h32, 8'h43);
        bus.in_valid = 4'b1111;
        mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            cycle();
            total++;
            if (bus.out_data !== exp_d[s] || bus.out_chan !== 2'(s)) begin
                bad++;
                $display("FAIL manual_sweep: got d=%h c=%0d expected d=%h c=%0d",
                         bus.out_data, bus.out_chan, exp_d[s], s);
            end
        end
    endtask

    task automatic test_backpressure();
        sel = 2'd1;
        cycle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            sel = 2'(i);
            cycle();
            total++;
            if (bus.out_data !== 8'h21 || bus.in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL backpressure_hold: got d=%h rdy=%b expected d=21 rdy=0000",
                         bus.out_data, bus.in_ready);
            end
        end
        set_data(8'h10, 8'h21, 8'h32, 8'h43);
        sel = 2'd3;
        bus.out_ready = 1'b1;
        cycle();
        total++;
        if (bus.out_data !== 8'h43 || bus.out_chan !== 2'd3) begin
            bad++;
            $display("FAIL backpressure_release: got d=%h c=%0d expected d=43 c=3",
                     bus.out_data, bus.out_chan);
        end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_c[6];
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        mode = 1'b1;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            cycle();
            total++;
            if (bus.out_chan !== exp_c[i]) begin
                bad++;
                $display("FAIL rr_fairness[%0d]: got c=%0d expected c=%0d",
                         i, bus.out_chan, exp_c[i]);
            end
        end
    endtask

    task automatic test_rr_wrap_skip();
        bus.in_valid = 4'b0100;
        cycle();
        bus.in_valid = 4'b0010;
        cycle();
        total++;
        if (bus.out_chan !== 2'd1 || bus.out_data !== 8'h21) begin
            bad++;
            $display("FAIL rr_wrap: got c=%0d d=%h expected c=1 d=21", bus.out_chan, bus.out_data);
        end
        bus.in_valid = 4'b0000;
        cycle();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rr_drain: got v=%b expected v=0", bus.out_valid);
        end
        bus.in_valid = 4'b1111;
        #1;
        total++;
        if (bus.in_ready !== 4'b0100) begin
            bad++;
            $display("FAIL rr_ptr_after_wrap: got rdy=%b expected rdy=0100", bus.in_ready);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.out_data, bus.out_chan, bus.in_ready} !== 15'd0) begin
            bad++;
            $display("FAIL reset_mid_clear: got v=%b d=%h c=%0d rdy=%b expected all zero",
                     bus.out_valid, bus.out_data, bus.out_chan, bus.in_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        total++;
        if (bus.out_chan !== 2'd0 || bus.out_data !== 8'h10) begin
            bad++;
            $display("FAIL reset_mid_first_grant: got c=%0d d=%h expected c=0 d=10",
                     bus.out_chan, bus.out_data);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_manual_sweep();
        test_backpressure();
        test_rr_fairness();
        test_rr_wrap_skip();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_stream_rr.md
# mux_stream_rr

Parametrised, registered N-channel stream multiplexer: the clocked successor to the 4:1 combinational mux. It selects one of N valid/ready input channels, either by an explicit `sel` or by round-robin arbitration, and forwards the word through a single output register. It sits between multiple producers and one consumer wherever a shared stream port is needed.

## Interface
Parameters:
- `WIDTH`, 8: data width per channel, at least 1.
- `N`, 4: channel count, at least 2. `SELW = $clog2(N)` is derived and is not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready (combinational).
- `mode`  in  1  0 = manual select, 1 = round-robin.
- `sel`  in  SELW  channel index used in mode 0.
- `out_data`  out  WIDTH  registered data.
- `out_valid`  out  1  registered valid.
- `out_chan`  out  SELW  source channel of the word in `out_data`.
- `out_ready`  in  1  consumer ready.

## Operation
- Internal state:
  - Output register holding `out_data`, `out_valid`, `out_chan`.
  - Round-robin pointer `ptr` (SELW bits).
- `load_en = !out_valid || out_ready`. The register accepts a new word when it is empty or is being drained in the same cycle.
- Grant is computed combinationally from the current `mode`, `sel`, `in_valid` and `ptr`:
  - Mode 0: `grant = sel`, `grant_ok = (sel < N)`. The grant does not depend on `in_valid`.
  - Mode 1: scan the channels `ptr, ptr+1, …` modulo N. `grant` is the first index with `in_valid` high, and `grant_ok = |in_valid`.
- `in_ready[i] = load_en && grant_ok && (i == grant)`. At most one `in_ready` bit is high in any cycle.
- Transfer on channel i occurs when `in_valid[i] && in_ready[i]`. On that clock edge:
  - `out_data` loads channel i's data, `out_chan` loads i, and `out_valid` is set to 1.
  - In mode 1 only, `ptr` loads `(i+1) mod N`. In mode 0, `ptr` is unchanged.
- If `load_en` is high and no transfer occurs, `out_valid` goes to 0. `out_data` and `out_chan` hold their last values.
- If `load_en` is low (`out_valid && !out_ready`):
  - All output registers hold.
  - All `in_ready` are 0.
  - Input changes have no effect.
- Mode or `sel` changes take effect in the same cycle's grant. The word already in the register is never altered by such a change.
- `sel >= N` (possible only when N is not a power of 2): no grant, `in_ready` is all 0, and the register drains normally.

## Timing
- Reset (asynchronous on `rst_n` low, released synchronously by design convention):
  - `out_valid = 0`, `out_data = 0`, `out_chan = 0`, `ptr = 0`.
  - `in_ready` is all 0 while in reset.
- Latency: a word accepted at edge k appears on `out_data`/`out_valid` immediately after edge k, and is consumed at the first edge ≥ k+1 with `out_ready` high.
- Throughput: one word per cycle with `out_ready` held high; there are no bubbles.
- Simultaneous drain and load: the new word replaces the old one in the same edge, and `out_valid` stays 1.
- Reset asserted mid-stream discards the held word and the pointer immediately, without waiting for a clock edge.
- Round-robin wrap: with `ptr = N-1`, the scan order is N-1, 0, 1, …, N-2.

## Test plan
- Reset:
  - Stimulus: drive `rst_n = 0` with all inputs toggling.
  - Required: `out_valid = 0`, `out_data = 0`, `out_chan = 0`, `in_ready = 0000`.
  - Stimulus: release reset with `out_ready = 1`, `mode = 0`, `sel = 2`, `in_valid = 0100`, channel 2 data = 8'hA5.
  - Required: one cycle later `out_data = A5`, `out_chan = 2`, `out_valid = 1`.
- Manual select sweep:
  - Stimulus: N=4, `mode = 0`, channel data = 8'h10, 8'h21, 8'h32, 8'h43, all valid, `out_ready = 1`, `sel` stepped 0→3 once per cycle.
  - Required: `out_data` = 10, 21, 32, 43 on consecutive cycles, with `out_chan` matching `sel`.
- Backpressure:
  - Stimulus: `out_valid = 1` with `out_data = 21`, then `out_ready = 0` for 3 cycles while `in_data` changes.
  - Required: `out_data` stays 21, `in_ready = 0000` throughout.
  - Stimulus: raise `out_ready`.
  - Required: the next word loads in that same cycle.
- Round-robin fairness:
  - Stimulus: `mode = 1`, all four valid continuously, `out_ready = 1`.
  - Required: `out_chan` sequence 0, 1, 2, 3, 0, 1.
- Round-robin wrap and skip:
  - Stimulus: `ptr = 3` (after a grant to channel 2), `in_valid = 0010`.
  - Required: channel 1 is granted and `ptr` becomes 2.
  - Stimulus: `in_valid = 0000`.
  - Required: `out_valid` falls to 0 after the drain.
- Reset mid-operation:
  - Stimulus: `rst_n` pulsed low between clock edges during round-robin traffic.
  - Required: outputs clear immediately, and after release the first grant goes to channel 0.
